// File: rtl/reorder_pkg.sv
// Shared status encodings for the reorder path.
// This package is used by the tag manager and by the circular buffer.
package reorder_pkg;

    typedef enum logic [1:0] {
        STATUS_PENDING  = 2'b00,
        STATUS_REJECTED = 2'b01,
        STATUS_ACCEPTED = 2'b11
    } status_e;

    function automatic status_e verdict_status(input logic accept);
        return accept ? STATUS_ACCEPTED : STATUS_REJECTED;
    endfunction

endpackage

// File: rtl/reorder_tag_manager_if.sv
// Interface that bundles the alloc, verdict, status and release signals of reorder_tag_manager.
// The circular buffer's "release" is carried as release_pkt, because "release" is a reserved word in SystemVerilog.
interface reorder_tag_manager_if #(
    parameter int TAG_WIDTH            = 6,
    parameter int CIRCULAR_BUFFER_SIZE = 50
) ();
    localparam int CNT_WIDTH = $clog2(CIRCULAR_BUFFER_SIZE + 1);

    logic                 alloc_req;
    logic                 alloc_grant;
    logic [TAG_WIDTH-1:0] alloc_tag;
    logic                 full;
    logic [CNT_WIDTH-1:0] in_flight;
    logic                 verdict_valid;
    logic [TAG_WIDTH-1:0] verdict_tag;
    logic                 verdict_accept;
    logic [TAG_WIDTH-1:0] reorder_tag_out;
    logic [1:0]           packet_status;
    logic                 release_pkt;

    modport master (
        output alloc_req, verdict_valid, verdict_tag, verdict_accept,
               reorder_tag_out, release_pkt,
        input  alloc_grant, alloc_tag, full, in_flight, packet_status
    );

    modport slave (
        input  alloc_req, verdict_valid, verdict_tag, verdict_accept,
               reorder_tag_out, release_pkt,
        output alloc_grant, alloc_tag, full, in_flight, packet_status
    );
endinterface

// File: rtl/reorder_status_table.sv
// Per-tag status and allocated bits.
// It has one write port with a release lane and a verdict lane, an allocate-set input, and combinational read and query ports.
module reorder_status_table
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH = 6,
    parameter int SIZE      = 50
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 set_en,
    input  logic [TAG_WIDTH-1:0] set_tag,
    input  logic                 vd_en,
    input  logic [TAG_WIDTH-1:0] vd_tag,
    input  status_e              vd_status,
    input  logic                 rel_en,
    input  logic [TAG_WIDTH-1:0] rel_tag,
    input  logic [TAG_WIDTH-1:0] rd_tag,
    output status_e              rd_status,
    input  logic [TAG_WIDTH-1:0] q_tag,
    output logic                 q_open
);
    localparam int IW = (SIZE > 1) ? $clog2(SIZE) : 1;
    localparam logic [TAG_WIDTH:0] LIMIT = (TAG_WIDTH + 1)'(SIZE);

    status_e           status_q [SIZE];
    status_e           status_d [SIZE];
    logic [SIZE-1:0]   alloc_q;
    logic [SIZE-1:0]   alloc_d;

    function automatic logic in_range(input logic [TAG_WIDTH-1:0] t);
        return ({1'b0, t} < LIMIT);
    endfunction

    // A release is applied after a verdict, so a release wins when both target the same slot.
    always_comb begin
        status_d = status_q;
        alloc_d  = alloc_q;
        if (set_en && in_range(set_tag))
            alloc_d[set_tag[IW-1:0]] = 1'b1;
        if (vd_en && in_range(vd_tag))
            status_d[vd_tag[IW-1:0]] = vd_status;
        if (rel_en && in_range(rel_tag)) begin
            status_d[rel_tag[IW-1:0]] = STATUS_PENDING;
            alloc_d[rel_tag[IW-1:0]]  = 1'b0;
        end
    end

    always_comb begin
        rd_status = STATUS_PENDING;
        q_open    = 1'b0;
        if (in_range(rd_tag))
            rd_status = status_q[rd_tag[IW-1:0]];
        if (in_range(q_tag))
            q_open = alloc_q[q_tag[IW-1:0]] && (status_q[q_tag[IW-1:0]] == STATUS_PENDING);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            status_q <= '{default: STATUS_PENDING};
            alloc_q  <= '0;
        end else begin
            status_q <= status_d;
            alloc_q  <= alloc_d;
        end
    end
endmodule

// File: rtl/reorder_tag_manager.sv
// Reorder tag allocator with head/tail pointers and an in-flight count over a status table.
// The optional sticky err output is enabled by the macro REORDER_ERR_CHECK_EN.
module reorder_tag_manager
    import reorder_pkg::*;
#(
    parameter int TAG_WIDTH            = 6,
    parameter int CIRCULAR_BUFFER_SIZE = 50
) (
    input  logic clk,
    input  logic rst,
    reorder_tag_manager_if.slave bus
`ifdef REORDER_ERR_CHECK_EN
    ,
    output logic err
`endif
);
    localparam int CW = $clog2(CIRCULAR_BUFFER_SIZE + 1);
    localparam logic [TAG_WIDTH-1:0] LAST_TAG = TAG_WIDTH'(CIRCULAR_BUFFER_SIZE - 1);
    localparam logic [CW-1:0]        SIZE_CNT = CW'(CIRCULAR_BUFFER_SIZE);

    logic [TAG_WIDTH-1:0] head_q, head_d;
    logic [TAG_WIDTH-1:0] tail_q, tail_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_int;
    logic                 grant;
    logic                 rel_ok;
    logic                 vd_open;
    logic                 vd_hits_head;
    logic                 vd_apply;
    status_e              rd_status;

    function automatic logic [TAG_WIDTH-1:0] next_ptr(input logic [TAG_WIDTH-1:0] p);
        return (p == LAST_TAG) ? '0 : p + 1'b1;
    endfunction

    // Full is taken from the registered count, so a release that arrives while the buffer is full cannot free a slot for an allocation in the same cycle.
    always_comb begin
        full_int     = (count_q == SIZE_CNT);
        grant        = rst && bus.alloc_req && !full_int;
        rel_ok       = rst && bus.release_pkt && (count_q != '0);
        vd_hits_head = rel_ok && (bus.verdict_tag == head_q);
        vd_apply     = rst && bus.verdict_valid && vd_open && !vd_hits_head;
        head_d       = rel_ok ? next_ptr(head_q) : head_q;
        tail_d       = grant ? next_ptr(tail_q) : tail_q;
        count_d      = count_q;
        if (grant && !rel_ok)
            count_d = count_q + 1'b1;
        else if (!grant && rel_ok)
            count_d = count_q - 1'b1;
    end

    always_comb begin
        bus.alloc_grant   = grant;
        bus.alloc_tag     = tail_q;
        bus.full          = rst && full_int;
        bus.in_flight     = rst ? count_q : '0;
        bus.packet_status = rst ? rd_status : STATUS_PENDING;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    reorder_status_table #(
        .TAG_WIDTH (TAG_WIDTH),
        .SIZE      (CIRCULAR_BUFFER_SIZE)
    ) u_table (
        .clk       (clk),
        .rst       (rst),
        .set_en    (grant),
        .set_tag   (tail_q),
        .vd_en     (vd_apply),
        .vd_tag    (bus.verdict_tag),
        .vd_status (verdict_status(bus.verdict_accept)),
        .rel_en    (rel_ok),
        .rel_tag   (head_q),
        .rd_tag    (bus.reorder_tag_out),
        .rd_status (rd_status),
        .q_tag     (bus.verdict_tag),
        .q_open    (vd_open)
    );

`ifdef REORDER_ERR_CHECK_EN
    logic err_q, err_d;

    always_comb begin
        err_d = err_q
              | (bus.verdict_valid && !vd_open)
              | (bus.release_pkt && (count_q == '0))
              | (bus.verdict_valid && vd_open && vd_hits_head);
    end

    always_ff @(posedge clk) begin
        if (!rst) err_q <= 1'b0;
        else      err_q <= err_d;
    end

    assign err = err_q;
`endif
endmodule
